// File: rtl/timer_irq_dev.sv
// timer_irq_dev: memory-mapped countdown timer with level interrupt.
//
// Register map (addr[3:2]):
//   0 CTRL   : bit0 EN, bits2:1 MODE (1 = auto-reload, others one-shot), bit3 IM
//   1 PRESET : reload value, R/W
//   2 COUNT  : current count, read-only
//   3 reserved, reads 0
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   addr   in   byte address, only addr[3:2] decoded
//   we     in   word write strobe (already qualified by the bridge)
//   wdata  in   store data
//   rdata  out  combinational read data for addr[3:2]
//   irq    out  level interrupt request
//
// Optional build macro: TIMER_PRESCALE_EN adds a 16-bit prescaler so COUNT
// only steps once every PRESCALE cycles while counting.

module timer_irq_dev #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    localparam logic [1:0] ModeReload = 2'd1;
    localparam logic [1:0] RegCtrl    = 2'd0;
    localparam logic [1:0] RegPreset  = 2'd1;
    localparam logic [1:0] RegCount   = 2'd2;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_prescale_range
        $error("timer_irq_dev: PRESCALE must be within 1..65535");
    end

    state_e      state_q;
    logic        en_q;
    logic [1:0]  mode_q;
    logic        im_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic ctrl_wr;
    logic preset_wr;
    logic fsm_set_flag;
    logic tick;
    logic unused_addr;

    assign ctrl_wr   = we && (addr[3:2] == RegCtrl);
    assign preset_wr = we && (addr[3:2] == RegPreset);
    // One-shot completion sets the flag this edge; a racing CTRL write must not clear it.
    assign fsm_set_flag = (state_q == StInt) && (mode_q != ModeReload);
    assign unused_addr  = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_PRESCALE_EN
    localparam logic [15:0] PscLast = 16'(PRESCALE - 1);

    logic [15:0] psc_q;

    // Runs only in CNT; wraps at PRESCALE-1, which is when COUNT is allowed to step.
    assign tick = (psc_q == PscLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
        end else if (state_q == StCnt && !tick) begin
            psc_q <= psc_q + 16'd1;
        end else begin
            psc_q <= '0;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_q) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!en_q) begin
                        state_q <= StIdle;
                    end else if (tick) begin
                        // COUNT saturates at zero; zero moves on to INT instead.
                        if (count_q == '0) begin
                            state_q <= StInt;
                        end else begin
                            count_q <= count_q - 32'd1;
                        end
                    end
                end
                StInt: begin
                    if (mode_q == ModeReload) begin
                        state_q <= StLoad;
                    end else begin
                        en_q       <= 1'b0;
                        irq_flag_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Bus writes come last so a written CTRL value overrides the FSM's EN clear.
            if (ctrl_wr) begin
                en_q   <= wdata[0];
                mode_q <= wdata[2:1];
                im_q   <= wdata[3];
                if (!fsm_set_flag) begin
                    irq_flag_q <= 1'b0;
                end
            end
            if (preset_wr) begin
                preset_q <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            RegCtrl:   rdata = {28'd0, im_q, mode_q, en_q};
            RegPreset: rdata = preset_q;
            RegCount:  rdata = count_q;
            default:   rdata = '0;
        endcase
    end

    // Auto-reload pulses for the single INT cycle; one-shot holds until CTRL is written.
    assign irq = im_q & ((mode_q == ModeReload) ? (state_q == StInt) : irq_flag_q);

endmodule

// File: tb/tb_timer_irq_dev.sv
module tb_timer_irq_dev;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    logic [31:0] p_addr;
    logic        p_we;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        p_irq;

    int n_vec;
    int n_err;

    timer_irq_dev #(
        .PRESCALE(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata),
        .irq  (irq)
    );

`ifdef TIMER_PRESCALE_EN
    timer_irq_dev #(
        .PRESCALE(4)
    ) dut_psc (
        .clk  (clk),
        .reset(reset),
        .addr (p_addr),
        .we   (p_we),
        .wdata(p_wdata),
        .rdata(p_rdata),
        .irq  (p_irq)
    );
`else
    assign p_rdata = '0;
    assign p_irq   = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 = main rdata at a, 1 = main irq, 2 = prescaled irq
    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic expect_rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_t x;
        x.sel = 0; x.a = a; x.exp = e; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic expect_irq(input int sel, input logic e, input string tag);
        exp_t x;
        x.sel = sel; x.a = '0; x.exp = {31'd0, e}; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t        x;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.sel == 0) begin
                addr = x.a;
                #1;
                obs = rdata;
            end else begin
                #1;
                obs = (x.sel == 1) ? {31'd0, irq} : {31'd0, p_irq};
            end
            n_vec++;
            assert (obs === x.exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr_p(input logic [31:0] a, input logic [31:0] d);
        p_addr  = a;
        p_wdata = d;
        p_we    = 1'b1;
        @(posedge clk);
        #1;
        p_we = 1'b0;
    endtask

    initial begin
        logic e;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        p_we    = 1'b0;
        p_addr  = '0;
        p_wdata = '0;

        // Reset state
        #12;
        expect_rd(32'h7F00, 32'h0, "rst_ctrl");
        expect_irq(1, 1'b0, "rst_irq");
        expect_rd(32'h7F04, 32'h0, "rst_preset");
        expect_rd(32'h7F08, 32'h0, "rst_count");
        drain();
        reset = 1'b1;
        step();

        // One-shot, PRESET=5: irq rises 9 cycles after the CTRL write edge
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        expect_irq(1, 1'b0, "t1_irq_c0");
        drain();
        step();
        step();
        for (int i = 5; i >= 0; i--) begin
            expect_rd(32'h7F08, 32'(i), "t1_count");
            expect_irq(1, 1'b0, "t1_irq_low");
            drain();
            step();
        end
        expect_irq(1, 1'b0, "t1_irq_int_cycle");
        drain();
        step();
        expect_irq(1, 1'b1, "t1_irq_rise");
        expect_rd(32'h7F10, 32'h8, "t1_ctrl_en_cleared");
        drain();
        step();
        expect_irq(1, 1'b1, "t1_irq_hold");
        expect_rd(32'h7F18, 32'h0, "t1_count_zero");
        drain();

        // CTRL write clears the one-shot flag
        wr(32'h7F00, 32'h8);
        expect_irq(1, 1'b0, "t2_irq_cleared");
        expect_rd(32'h7F08, 32'h0, "t2_count_zero");
        drain();
        step();
        expect_irq(1, 1'b0, "t2_irq_stays_low");
        drain();

        // Auto-reload PRESET=3: pulse every 6 cycles; PRESET=1 mid-count -> period 4 after next LOAD
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'hB);
        expect_irq(1, 1'b0, "t3_irq_c0");
        drain();
        for (int c = 1; c <= 52; c++) begin
            if (c == 34) wr(32'h7F04, 32'd1);
            else step();
            e = (c >= 6 && c <= 36 && (c % 6) == 0) || (c > 36 && ((c - 36) % 4) == 0);
            expect_irq(1, e, "t3_irq_pulse");
            if (c == 34) expect_rd(32'h7F08, 32'd1, "t3_count_unaffected_by_preset");
            if (c == 38) expect_rd(32'h7F08, 32'd1, "t3_count_new_preset");
            drain();
        end
        expect_rd(32'h7F00, 32'hB, "t3_ctrl_en_kept");
        drain();

        // Stop, then async reset mid-count at COUNT=7
        wr(32'h7F00, 32'h0);
        for (int i = 0; i < 4; i++) step();
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h1);
        for (int i = 0; i < 5; i++) step();
        expect_rd(32'h7F08, 32'd7, "t4_count_before_reset");
        drain();
        #2;
        reset = 1'b0;
        expect_rd(32'h7F00, 32'h0, "t4_ctrl_async_rst");
        expect_rd(32'h7F04, 32'h0, "t4_preset_async_rst");
        expect_rd(32'h7F08, 32'h0, "t4_count_async_rst");
        expect_irq(1, 1'b0, "t4_irq_async_rst");
        drain();
        step();
        step();
        reset = 1'b1;
        step();

        // Stop during CNT: one extra decrement on the write edge, then frozen; COUNT is read-only
        wr(32'h7F04, 32'd20);
        wr(32'h7F00, 32'h1);
        step();
        step();
        expect_rd(32'h7F08, 32'd20, "t4_count_loaded");
        drain();
        wr(32'h7F00, 32'h0);
        expect_rd(32'h7F08, 32'd19, "t4_count_last_dec");
        drain();
        step();
        step();
        expect_rd(32'h7F08, 32'd19, "t4_count_frozen");
        expect_rd(32'h7F00, 32'h0, "t4_ctrl_stopped");
        drain();
        wr(32'h7F08, 32'h1234);
        expect_rd(32'h7F08, 32'd19, "t4_count_write_ignored");
        drain();
        wr(32'h7F0C, 32'hFFFF_FFFF);
        expect_rd(32'h7F0C, 32'h0, "t4_reserved_reads_zero");
        expect_rd(32'h7F04, 32'd20, "t4_preset_intact");
        expect_rd(32'h7F00, 32'h0, "t4_ctrl_intact");
        drain();

        // CTRL write on the exact one-shot INT edge: flag set wins, written CTRL wins
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        for (int i = 0; i < 5; i++) step();
        expect_irq(1, 1'b0, "t5_irq_in_int");
        drain();
        wr(32'h7F00, 32'hD);
        expect_rd(32'h7F00, 32'hD, "t5_ctrl_written_wins");
        expect_irq(1, 1'b1, "t5_flag_set_wins");
        drain();
        step();
        expect_irq(1, 1'b1, "t5_irq_held");
        drain();

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=4, PRESET=2, auto-reload -> period 14
        wr_p(32'h7F04, 32'd2);
        wr_p(32'h7F00, 32'hB);
        expect_irq(2, 1'b0, "psc_irq_c0");
        drain();
        for (int c = 1; c <= 44; c++) begin
            step();
            e = (c >= 14) && ((c % 14) == 0);
            expect_irq(2, e, "psc_irq_pulse");
            drain();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_irq_dev.md
Name: timer_irq_dev

Overview:
- Memory-mapped countdown timer on the CPU data bus in the 0x7F00/0x7F10 windows; the bridge instantiates two copies.
- Consumes the M-stage store stream (address, write enable, write data) and returns combinational read data for M-stage loads.
- Produces the level interrupt that drives one HWINT bit into the CPU's CP0.
- Word access only: the CPU already raises AdEL/AdES for byte/halfword access to this window and for stores to COUNT. The block must still be safe if such accesses arrive.

Parameters:
- PRESCALE, 1, cycles per count decrement. Used only when TIMER_PRESCALE_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the bridge; only addr[3:2] decoded.
- we  in  1  word write strobe, already gated by the bridge (byteen==4'b1111 and window hit).
- wdata  in  32  store data.
- rdata  out  32  combinational read data for the register at addr[3:2].
- irq  out  1  interrupt request, level, to HWINT.

Behaviour:
- Register map (addr[3:2]):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits 31:4 read 0.
  - 1 PRESET: R/W, 32 bits.
  - 2 COUNT: read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Reset (reset==0, async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. With rdata at addr 0 this gives rdata=0 and irq=0.
- Writes commit at the rising edge where we==1.
  - The FSM at that same edge sees the pre-write CTRL/PRESET values.
  - A PRESET write does not alter COUNT until the next LOAD.
- FSM, one transition per clk:
  - IDLE: if EN, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT frozen. Else if COUNT==0, go to INT. Else COUNT<=COUNT-1.
  - INT, MODE==1 (auto-reload): go to LOAD; irq_flag untouched.
  - INT, MODE==0/2/3 (one-shot): EN<=0 and irq_flag<=1; go to IDLE.
- Latency: with PRESET=N and EN set at edge t:
  - state is LOAD in cycle t+1 and CNT from t+2;
  - INT is reached in cycle t+N+3;
  - one-shot irq rises in cycle t+N+4.
- irq = IM & (MODE==1 ? (state==INT) : irq_flag).
  - Auto-reload gives exactly a 1-cycle pulse per period of N+3 cycles.
  - One-shot holds the level until irq_flag is cleared.
- irq_flag is cleared by any CTRL write.
- Simultaneous events:
  - FSM setting irq_flag on the same edge as a CTRL write: the set wins, so no interrupt is lost.
  - FSM clearing EN in INT on the same edge as a CTRL write: the written CTRL value wins.
  - CTRL write clearing EN while in CNT: state goes to IDLE one cycle later. COUNT may decrement once more on the write edge.
- Reset asserted mid-count returns everything to reset values immediately, regardless of clk.
- Wrap-around: COUNT never decrements below 0. PRESET=0 reaches INT directly after LOAD+CNT.
- No combinational path from wdata or we to irq.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined: a 16-bit prescale counter is added.
  - In CNT it counts 0..PRESCALE-1; COUNT decrements and the COUNT==0 test is made only when it wraps.
  - The prescale counter clears in IDLE and LOAD and on reset.
  - Period becomes N*PRESCALE + PRESCALE + 2 cycles for auto-reload.
- Undefined: decrement every cycle, PRESCALE ignored, no prescale logic synthesized.

Test Plan:
- Reset, then write PRESET=5 and CTRL=0x9 (EN, one-shot, IM); hold idle -> COUNT reads 5,4,3,2,1,0, irq rises 9 cycles after the CTRL write edge and stays high, and CTRL reads 0x8.
- With irq high from the previous test, write CTRL=0x8 -> irq low next cycle and COUNT stays 0.
- Write PRESET=3 and CTRL=0xB (auto-reload, IM) -> irq is a 1-cycle pulse every 6 cycles for ≥4 periods and EN stays 1. Then PRESET=1 mid-count -> the period changes to 4 only after the next LOAD.
- Mid-count (COUNT=7), assert reset low between clock edges -> rdata for CTRL, PRESET and COUNT reads 0 immediately and irq=0. Write to COUNT (addr 0x8, 0x1234) -> COUNT unchanged. Read of addr 0xC -> 0.
- Force a CTRL write on the exact INT edge of one-shot mode -> irq_flag ends at 1 and CTRL equals the written value.
- With TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2, auto-reload -> irq pulse period 14 cycles.
